// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: retire-trace capture that classifies writeback commits, tags them with an instruction number and buffers them in a FWFT FIFO
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   c_valid .. c_halt          commit bus from the writeback stage
//   out_valid/out_ready        valid/ready drain of the head record
//   out_kind .. out_addr       head record fields (zero when the FIFO is empty)
//   overflow, wdog_trip        sticky status flags
//   done                       halt record drained, or watchdog tripped
//   inst_count, cycle_count    accepted commits, cycles since reset release
// Build option TRACE_TIMESTAMP_EN adds out_cycle, the cycle_count value captured with each record.
module commit_trace_fifo #(
  parameter int DW         = 16,
  parameter int AW         = 16,
  parameter int RAW        = 4,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           c_valid,
  input  logic [AW-1:0]  c_pc,
  input  logic           c_reg_we,
  input  logic [RAW-1:0] c_reg_addr,
  input  logic [DW-1:0]  c_reg_data,
  input  logic           c_mem_rd,
  input  logic           c_mem_we,
  input  logic [AW-1:0]  c_mem_addr,
  input  logic [DW-1:0]  c_mem_data,
  input  logic           c_halt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2:0]     out_kind,
  output logic [31:0]    out_inum,
  output logic [AW-1:0]  out_pc,
  output logic [RAW-1:0] out_reg,
  output logic [DW-1:0]  out_data,
  output logic [AW-1:0]  out_addr,
  output logic           overflow,
  output logic           done,
  output logic           wdog_trip,
  output logic [31:0]    inst_count,
`ifdef TRACE_TIMESTAMP_EN
  output logic [31:0]    out_cycle,
`endif
  output logic [31:0]    cycle_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = 3 + 32 + AW + RAW + DW + AW;
`ifdef TRACE_TIMESTAMP_EN
  localparam int EW = BW + 32;
`else
  localparam int EW = BW;
`endif
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t          state_q, state_d;
  logic [PW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     inst_q, cyc_q;
  logic            ovf_q, wdog_q;
  logic [EW-1:0]   mem_q [DEPTH];
  logic            accept, is_load, is_reg, is_halt, is_store;
  logic            full, pop, push, drop, wdog_hit;
  logic [2:0]      kind;
  logic [BW-1:0]   rec;
  logic [EW-1:0]   entry, head;
  assign accept   = c_valid && state_q == RUN;
  assign is_load  = c_reg_we && c_mem_rd;
  assign is_reg   = c_reg_we && !c_mem_rd;
  assign is_halt  = !c_reg_we && c_halt;
  assign is_store = !c_reg_we && !c_halt && c_mem_we;
  assign kind     = is_load ? 3'd2 : is_reg ? 3'd1 : is_halt ? 3'd4 : is_store ? 3'd3 : 3'd0;
  // REG and LOAD are exactly the commits with c_reg_we set
  assign rec = {kind, inst_q, c_pc,
                c_reg_we ? c_reg_addr : RAW'(0),
                c_reg_we ? c_reg_data : is_store ? c_mem_data : DW'(0),
                (is_load || is_store) ? c_mem_addr : AW'(0)};
  assign out_valid = cnt_q != '0;
  assign full      = cnt_q == CW'(DEPTH);
  assign pop       = out_valid && out_ready;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign push      = accept && (!full || pop);
  assign drop      = accept && full && !pop;
  assign cnt_d     = cnt_q + CW'(push) - CW'(pop);
  assign wdog_hit  = state_q == RUN && cyc_q == 32'(MAX_CYCLES - 1);
  // DRAIN looks at next-cycle occupancy so done follows the final pop by one cycle
  assign state_d = wdog_hit ? DONE :
                   (accept && is_halt) ? DRAIN :
                   (state_q == DRAIN && cnt_d == '0) ? DONE : state_q;
  // fields read as zero while empty so stale storage never shows
  assign head = out_valid ? mem_q[rd_q] : '0;
  assign {out_kind, out_inum, out_pc, out_reg, out_data, out_addr} = head[BW-1:0];
`ifdef TRACE_TIMESTAMP_EN
  assign entry     = {cyc_q, rec};
  assign out_cycle = head[EW-1:BW];
`else
  assign entry = rec;
`endif
  assign overflow    = ovf_q;
  assign wdog_trip   = wdog_q;
  assign done        = state_q == DONE;
  assign inst_count  = inst_q;
  assign cycle_count = cyc_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      inst_q  <= '0;
      cyc_q   <= '0;
      ovf_q   <= 1'b0;
      wdog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (accept) inst_q <= inst_q + 32'd1;
      if (state_q != DONE && cyc_q != 32'(MAX_CYCLES)) cyc_q <= cyc_q + 32'd1;
      ovf_q  <= ovf_q | drop;
      wdog_q <= wdog_q | wdog_hit;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= entry;
  end
endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb_commit_trace_fifo: self-checking bench for commit_trace_fifo with a queue-based reference model
module tb_commit_trace_fifo;
  localparam int DW = 16, AW = 16, RAW = 4, DEPTH = 16, MAXC = 20000, WMAX = 50;
  logic clk = 1'b0, rst_n = 1'b0;
  logic c_valid = 1'b0, c_reg_we = 1'b0, c_mem_rd = 1'b0, c_mem_we = 1'b0, c_halt = 1'b0;
  logic [AW-1:0] c_pc = '0, c_mem_addr = '0;
  logic [RAW-1:0] c_reg_addr = '0;
  logic [DW-1:0] c_reg_data = '0, c_mem_data = '0;
  logic out_ready = 1'b0, wd_valid = 1'b0, wd_ready = 1'b0;
  logic out_valid, overflow, done, wdog_trip;
  logic [2:0] out_kind;
  logic [31:0] out_inum, inst_count, cycle_count, out_cycle;
  logic [AW-1:0] out_pc, out_addr;
  logic [RAW-1:0] out_reg;
  logic [DW-1:0] out_data;
  logic wd_ov, wd_ovf, wd_done, wd_wdog;
  logic [2:0] wd_kind;
  logic [31:0] wd_inum, wd_inst, wd_cyc, wd_ocyc;
  logic [AW-1:0] wd_pc, wd_addr;
  logic [RAW-1:0] wd_reg;
  logic [DW-1:0] wd_data;
  int checks = 0, errors = 0;
  logic mon = 1'b0, wd_fin = 1'b0;
  always #5 clk = ~clk;
  commit_trace_fifo #(.DW(DW), .AW(AW), .RAW(RAW), .DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .c_valid(c_valid), .c_pc(c_pc), .c_reg_we(c_reg_we),
    .c_reg_addr(c_reg_addr), .c_reg_data(c_reg_data), .c_mem_rd(c_mem_rd), .c_mem_we(c_mem_we),
    .c_mem_addr(c_mem_addr), .c_mem_data(c_mem_data), .c_halt(c_halt), .out_valid(out_valid),
    .out_ready(out_ready), .out_kind(out_kind), .out_inum(out_inum), .out_pc(out_pc),
    .out_reg(out_reg), .out_data(out_data), .out_addr(out_addr), .overflow(overflow),
    .done(done), .wdog_trip(wdog_trip), .inst_count(inst_count),
`ifdef TRACE_TIMESTAMP_EN
    .out_cycle(out_cycle),
`endif
    .cycle_count(cycle_count));
  commit_trace_fifo #(.DW(DW), .AW(AW), .RAW(RAW), .DEPTH(DEPTH), .MAX_CYCLES(WMAX)) wd (
    .clk(clk), .rst_n(rst_n), .c_valid(wd_valid), .c_pc(c_pc), .c_reg_we(c_reg_we),
    .c_reg_addr(c_reg_addr), .c_reg_data(c_reg_data), .c_mem_rd(c_mem_rd), .c_mem_we(c_mem_we),
    .c_mem_addr(c_mem_addr), .c_mem_data(c_mem_data), .c_halt(c_halt), .out_valid(wd_ov),
    .out_ready(wd_ready), .out_kind(wd_kind), .out_inum(wd_inum), .out_pc(wd_pc),
    .out_reg(wd_reg), .out_data(wd_data), .out_addr(wd_addr), .overflow(wd_ovf),
    .done(wd_done), .wdog_trip(wd_wdog), .inst_count(wd_inst),
`ifdef TRACE_TIMESTAMP_EN
    .out_cycle(wd_ocyc),
`endif
    .cycle_count(wd_cyc));
`ifndef TRACE_TIMESTAMP_EN
  assign out_cycle = '0;
  assign wd_ocyc = '0;
`endif
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // reference model: a queue of records plus counters, updated per clock from the commit rules
  typedef struct {logic [2:0] k; logic [31:0] inum, cyc; logic [15:0] pc, data, addr; logic [3:0] rg;} rec_t;
  rec_t q[$];
  rec_t r;
  logic [31:0] m_inst = 0, m_cyc = 0;
  logic m_ovf = 0, m_wdog = 0, m_pop, m_full, m_wd;
  int m_phase = 0, ph;
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete(); m_inst = 0; m_cyc = 0; m_ovf = 0; m_wdog = 0; m_phase = 0;
    end else begin
      ph = m_phase;
      m_pop = q.size() != 0 && out_ready;
      m_full = q.size() == DEPTH;
      m_wd = ph == 0 && m_cyc == 32'(MAXC - 1);
      if (m_pop) q.delete(0);
      if (ph == 0 && c_valid) begin
        if (c_reg_we && c_mem_rd) r.k = 3'd2;
        else if (c_reg_we) r.k = 3'd1;
        else if (c_halt) r.k = 3'd4;
        else if (c_mem_we) r.k = 3'd3;
        else r.k = 3'd0;
        r.inum = m_inst; r.cyc = m_cyc; r.pc = c_pc;
        r.rg = (r.k == 1 || r.k == 2) ? c_reg_addr : 4'd0;
        r.data = (r.k == 1 || r.k == 2) ? c_reg_data : (r.k == 3) ? c_mem_data : 16'd0;
        r.addr = (r.k == 2 || r.k == 3) ? c_mem_addr : 16'd0;
        if (!m_full || m_pop) q.push_back(r); else m_ovf = 1;
        m_inst = m_inst + 1;
        if (r.k == 4) m_phase = 1;
      end
      if (ph != 2 && m_cyc < MAXC) m_cyc = m_cyc + 1;
      if (m_wd) begin m_wdog = 1; m_phase = 2; end
      else if (ph == 1 && q.size() == 0) m_phase = 2;
    end
  end
  always @(negedge clk) if (mon) begin
    chk("m_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("m_kind", 32'(out_kind), 32'(q[0].k));
      chk("m_inum", out_inum, q[0].inum);
      chk("m_pc", 32'(out_pc), 32'(q[0].pc));
      chk("m_reg", 32'(out_reg), 32'(q[0].rg));
      chk("m_data", 32'(out_data), 32'(q[0].data));
      chk("m_addr", 32'(out_addr), 32'(q[0].addr));
`ifdef TRACE_TIMESTAMP_EN
      chk("m_tstamp", out_cycle, q[0].cyc);
`endif
    end else begin
      chk("m_idle_fields", {out_kind, out_reg, out_pc, out_data[8:0]}, 32'd0);
      chk("m_idle_inum", out_inum, 32'd0);
    end
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
    chk("m_done", 32'(done), 32'(m_phase == 2));
    chk("m_wdog", 32'(wdog_trip), 32'(m_wdog));
    chk("m_inst", inst_count, m_inst);
    chk("m_cyc", cycle_count, m_cyc);
  end
  typedef struct {
    logic we, rd, mwe, halt; logic [15:0] pc; logic [3:0] ra; logic [15:0] rdata, maddr, mdata;
    logic [2:0] ek; logic [3:0] ereg; logic [15:0] edata, eaddr;
  } vec_t;
  vec_t tbl[6];
  task automatic commit_rand();
    c_reg_we = 1'($urandom); c_mem_rd = 1'($urandom); c_mem_we = 1'($urandom);
    c_halt = c_reg_we & 1'($urandom);
    c_pc = 16'($urandom); c_reg_addr = 4'($urandom); c_reg_data = 16'($urandom);
    c_mem_addr = 16'($urandom); c_mem_data = 16'($urandom);
  endtask
  task automatic drain(input int n, input logic [31:0] first);
    int cnt = 0;
    c_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 40 && out_valid; t++) begin
      chk("drain_inum", out_inum, first + 32'(cnt));
      cnt++;
      @(negedge clk);
    end
    chk("drain_count", 32'(cnt), 32'(n));
    out_ready = 1'b0;
  endtask
  initial begin
    @(posedge rst_n);
    repeat (49) @(negedge clk);
    chk("wd_pre_trip", 32'(wd_wdog), 0);
    chk("wd_pre_done", 32'(wd_done), 0);
    chk("wd_cyc49", wd_cyc, 49);
    @(negedge clk);
    chk("wd_trip", 32'(wd_wdog), 1);
    chk("wd_done", 32'(wd_done), 1);
    chk("wd_cyc50", wd_cyc, 50);
    repeat (3) @(negedge clk);
    chk("wd_cyc_hold", wd_cyc, 50);
    chk("wd_inst", wd_inst, 3);
    wd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("wd_valid", 32'(wd_ov), 1);
      chk("wd_kind", 32'(wd_kind), 0);
      chk("wd_pc", 32'(wd_pc), 32'(2 + i));
      chk("wd_inum", wd_inum, 32'(i));
`ifdef TRACE_TIMESTAMP_EN
      chk("wd_tstamp", wd_ocyc, 32'(2 + i));
`endif
      @(negedge clk);
    end
    chk("wd_empty", 32'(wd_ov), 0);
    wd_ready = 1'b0;
    wd_fin = 1'b1;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    logic seen;
    tbl[0] = '{1,0,0,0, 16'h0002, 4'd3, 16'h00AB, 16'h0999, 16'h7777, 3'd1, 4'd3, 16'h00AB, 16'h0000};
    tbl[1] = '{1,1,0,0, 16'h0004, 4'd1, 16'h1234, 16'h0010, 16'h1111, 3'd2, 4'd1, 16'h1234, 16'h0010};
    tbl[2] = '{0,0,1,0, 16'h0006, 4'd5, 16'h4444, 16'h0020, 16'h5555, 3'd3, 4'd0, 16'h5555, 16'h0020};
    tbl[3] = '{0,0,0,0, 16'h0008, 4'd7, 16'h0001, 16'h0030, 16'h0002, 3'd0, 4'd0, 16'h0000, 16'h0000};
    tbl[4] = '{1,0,1,1, 16'h000A, 4'd9, 16'hBEEF, 16'h0040, 16'h0003, 3'd1, 4'd9, 16'hBEEF, 16'h0000};
    tbl[5] = '{0,1,1,0, 16'h000C, 4'd2, 16'h0004, 16'h0050, 16'hCAFE, 3'd3, 4'd0, 16'hCAFE, 16'h0050};
    repeat (2) @(negedge clk);
    mon = 1'b1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_flags", {29'd0, overflow, done, wdog_trip}, 0);
    chk("rst_inst", inst_count, 0);
    chk("rst_cyc", cycle_count, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      c_pc = 16'(i);
      wd_valid = i >= 2 && i <= 4;
      @(negedge clk);
    end
    wd_valid = 1'b0;
    chk("idle_cyc", cycle_count, 10);
    chk("idle_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      {c_reg_we, c_mem_rd, c_mem_we, c_halt} = {tbl[i].we, tbl[i].rd, tbl[i].mwe, tbl[i].halt};
      c_pc = tbl[i].pc; c_reg_addr = tbl[i].ra; c_reg_data = tbl[i].rdata;
      c_mem_addr = tbl[i].maddr; c_mem_data = tbl[i].mdata; c_valid = 1'b1;
      @(negedge clk);
      chk("tbl_valid", 32'(out_valid), 1);
      chk("tbl_kind", 32'(out_kind), 32'(tbl[i].ek));
      chk("tbl_inum", out_inum, 32'(i));
      chk("tbl_pc", 32'(out_pc), 32'(tbl[i].pc));
      chk("tbl_reg", 32'(out_reg), 32'(tbl[i].ereg));
      chk("tbl_data", 32'(out_data), 32'(tbl[i].edata));
      chk("tbl_addr", 32'(out_addr), 32'(tbl[i].eaddr));
    end
    c_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (16) begin commit_rand(); c_valid = 1'b1; @(negedge clk); end
    commit_rand(); out_ready = 1'b1;
    @(negedge clk);
    c_valid = 1'b0; out_ready = 1'b0;
    chk("fullpop_ovf", 32'(overflow), 0);
    chk("fullpop_inst", inst_count, 23);
    @(negedge clk);
    drain(16, 7);
    chk("fullpop_ovf_after", 32'(overflow), 0);
    repeat (20) begin commit_rand(); c_valid = 1'b1; @(negedge clk); end
    c_valid = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_inst", inst_count, 43);
    drain(16, 23);
    repeat (400) begin
      commit_rand();
      c_valid = $urandom_range(0, 2) != 0;
      out_ready = 1'($urandom);
      @(negedge clk);
    end
    c_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(negedge clk);
    for (int t = 0; t < 200 && !wd_fin; t++) @(negedge clk);
    chk("wd_finished", 32'(wd_fin), 1);
    out_ready = 1'b0;
    repeat (5) begin commit_rand(); c_valid = 1'b1; @(negedge clk); end
    c_valid = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_inst", inst_count, 0);
    rst_n = 1'b1;
    repeat (3) begin commit_rand(); c_valid = 1'b1; @(negedge clk); end
    c_reg_we = 1'b0; c_halt = 1'b1; c_mem_we = 1'b1; c_pc = 16'h0030;
    @(negedge clk);
    repeat (3) begin commit_rand(); @(negedge clk); end
    c_valid = 1'b0;
    chk("halt_inst", inst_count, 4);
    chk("halt_not_done", 32'(done), 0);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (out_valid && out_kind == 3'd4) begin
        seen = 1'b1;
        chk("halt_inum", out_inum, 3);
        chk("halt_pc", 32'(out_pc), 32'h30);
        chk("halt_done_pre", 32'(done), 0);
      end
      @(negedge clk);
    end
    chk("halt_seen", 32'(seen), 1);
    chk("halt_done", 32'(done), 1);
    chk("halt_empty", 32'(out_valid), 0);
    commit_rand(); c_valid = 1'b1;
    repeat (2) @(negedge clk);
    c_valid = 1'b0;
    chk("done_ignore_inst", inst_count, 4);
    chk("done_ignore_valid", 32'(out_valid), 0);
    mon = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
